// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU op codes, SREG bit
// positions, the flag bundle order and the issue FSM states.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_CPC  = 4'd1;
    localparam logic [3:0] OP_SBC  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_CPSE = 4'd4;
    localparam logic [3:0] OP_CP   = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_ADC  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_EOR  = 4'd9;
    localparam logic [3:0] OP_OR   = 4'd10;
    localparam logic [3:0] OP_MOV  = 4'd11;

    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;
    localparam int SREG_S = 4;
    localparam int SREG_H = 5;
    localparam int SREG_T = 6;
    localparam int SREG_I = 7;

    // ALU flag bundle, MSB first: {H,S,V,N,Z,C}; matches SREG[5:0].
    typedef struct packed {
        logic h;
        logic s;
        logic v;
        logic n;
        logic z;
        logic c;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } issue_state_e;

    function automatic logic is_legal(input logic [15:0] instr);
        return (instr[15:14] == 2'b00) && (instr[13:10] != OP_NOP);
    endfunction

    function automatic logic op_writes_rd(input logic [3:0] op);
        logic wr;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC,
            OP_AND, OP_EOR, OP_OR, OP_MOV: wr = 1'b1;
            default:                       wr = 1'b0;
        endcase
        return wr;
    endfunction

    function automatic logic op_writes_sreg(input logic [3:0] op);
        return (op != OP_MOV) && (op != OP_CPSE);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_gpr_file.sv
// 32 x 8 general-purpose register file: two combinational read ports and two
// write ports; port 0 (write-back) wins over port 1 on an address collision.
module alu_issue_ctrl_gpr_file (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [4:0] rd_addr0_i,
    output logic [7:0] rd_data0_o,
    input  logic [4:0] rd_addr1_i,
    output logic [7:0] rd_data1_o,
    input  logic       wr0_en_i,
    input  logic [4:0] wr0_addr_i,
    input  logic [7:0] wr0_data_i,
    input  logic       wr1_en_i,
    input  logic [4:0] wr1_addr_i,
    input  logic [7:0] wr1_data_i
);

    logic [7:0] regs_q [32];
    logic       wr1_keep;

    assign rd_data0_o = regs_q[rd_addr0_i];
    assign rd_data1_o = regs_q[rd_addr1_i];
    assign wr1_keep   = wr1_en_i && !(wr0_en_i && (wr0_addr_i == wr1_addr_i));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            if (wr1_keep) begin
                regs_q[wr1_addr_i] <= wr1_data_i;
            end
            if (wr0_en_i) begin
                regs_q[wr0_addr_i] <= wr0_data_i;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for two-register AVR ALU instructions: IDLE -> ISSUE -> WB.
// Build option ALU_ISSUE_ILLEGAL_EN: illegal words pulse o_illegal instead of retiring as NOPs.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_instr_valid,
    input  logic [15:0] i_instr,
    output logic        o_instr_ready,
    output logic        o_done,
    output logic        o_skip,
    output logic        o_illegal,
    input  logic        i_ld_en,
    input  logic [4:0]  i_ld_addr,
    input  logic [7:0]  i_ld_data,
    output logic [3:0]  o_alu_operation,
    output logic [7:0]  o_alu_op1,
    output logic [7:0]  o_alu_op2,
    output logic [5:0]  o_alu_flags,
    input  logic [7:0]  i_alu_result,
    input  logic [5:0]  i_alu_flags,
    output logic [7:0]  o_sreg,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a word transfers on a cycle with i_instr_valid && o_instr_ready
    // and i_reset low; ready is high only in IDLE, and valid need not be held.
    issue_state_e state_q, state_d;
    logic [3:0]   op_q;
    logic [4:0]   d_q, r_q;
    logic         legal_q, eq_q;
    alu_flags_t   flags_q;
    logic [7:0]   rd_val, rr_val;
    logic         accept, wb_rd_en, sreg_we;

    assign accept      = (state_q == ST_IDLE) && i_instr_valid;
    assign o_dbg_state = state_q;

    always_comb begin
        o_sreg         = 8'h00;
        o_sreg[SREG_H] = flags_q.h;
        o_sreg[SREG_S] = flags_q.s;
        o_sreg[SREG_V] = flags_q.v;
        o_sreg[SREG_N] = flags_q.n;
        o_sreg[SREG_Z] = flags_q.z;
        o_sreg[SREG_C] = flags_q.c;
        o_sreg[SREG_T] = 1'b0;
        o_sreg[SREG_I] = 1'b0;
    end

    alu_issue_ctrl_gpr_file u_gpr (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .rd_addr0_i (d_q),
        .rd_data0_o (rd_val),
        .rd_addr1_i (r_q),
        .rd_data1_o (rr_val),
        .wr0_en_i   (wb_rd_en),
        .wr0_addr_i (d_q),
        .wr0_data_i (i_alu_result),
        .wr1_en_i   (i_ld_en),
        .wr1_addr_i (i_ld_addr),
        .wr1_data_i (i_ld_data)
    );

    always_comb begin
        state_d         = state_q;
        o_instr_ready   = 1'b0;
        o_done          = 1'b0;
        o_skip          = 1'b0;
        o_illegal       = 1'b0;
        o_alu_operation = OP_NOP;
        o_alu_op1       = 8'h00;
        o_alu_op2       = 8'h00;
        o_alu_flags     = 6'h00;
        wb_rd_en        = 1'b0;
        sreg_we         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WB;
                // Illegal words keep the ALU on its no-op.
                if (legal_q) begin
                    o_alu_operation = op_q;
                    o_alu_op1       = rd_val;
                    o_alu_op2       = rr_val;
                    o_alu_flags     = flags_q;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
                if (legal_q) begin
                    o_done   = 1'b1;
                    o_skip   = (op_q == OP_CPSE) && eq_q;
                    wb_rd_en = op_writes_rd(op_q);
                    sreg_we  = op_writes_sreg(op_q);
                end else begin
`ifdef ALU_ISSUE_ILLEGAL_EN
                    o_illegal = 1'b1;
`else
                    o_done    = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            d_q     <= 5'd0;
            r_q     <= 5'd0;
            legal_q <= 1'b0;
            eq_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= i_instr[13:10];
                d_q     <= i_instr[8:4];
                r_q     <= {i_instr[9], i_instr[3:0]};
                legal_q <= is_legal(i_instr);
            end
            // CPSE equality comes from this local compare, not the ALU Z flag.
            if (state_q == ST_ISSUE) begin
                eq_q <= (rd_val == rr_val);
            end
            if (sreg_we) begin
                flags_q <= i_alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural AVR ALU attached.
// Honours ALU_ISSUE_ILLEGAL_EN in the same way as the design.
module tb_alu_issue_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_instr_valid;
    logic [15:0] i_instr;
    logic        o_instr_ready, o_done, o_skip, o_illegal;
    logic        i_ld_en;
    logic [4:0]  i_ld_addr;
    logic [7:0]  i_ld_data;
    logic [3:0]  o_alu_operation;
    logic [7:0]  o_alu_op1, o_alu_op2;
    logic [5:0]  o_alu_flags;
    logic [7:0]  i_alu_result;
    logic [5:0]  i_alu_flags;
    logic [7:0]  o_sreg;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_regs [32];
    logic [5:0] m_flags;

    always #5 i_clk = ~i_clk;

    alu_issue_ctrl dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_instr_valid   (i_instr_valid),
        .i_instr         (i_instr),
        .o_instr_ready   (o_instr_ready),
        .o_done          (o_done),
        .o_skip          (o_skip),
        .o_illegal       (o_illegal),
        .i_ld_en         (i_ld_en),
        .i_ld_addr       (i_ld_addr),
        .i_ld_data       (i_ld_data),
        .o_alu_operation (o_alu_operation),
        .o_alu_op1       (o_alu_op1),
        .o_alu_op2       (o_alu_op2),
        .o_alu_flags     (o_alu_flags),
        .i_alu_result    (i_alu_result),
        .i_alu_flags     (i_alu_flags),
        .o_sreg          (o_sreg),
        .o_dbg_state     (o_dbg_state)
    );

    // AVR arithmetic in plain integers; returns {result, H,S,V,N,Z,C}.
    function automatic logic [13:0] avr_alu(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [5:0] f);
        int ai, bi, cin, res;
        logic [7:0] r;
        logic h, s, v, n, z, c;
        ai = int'(a); bi = int'(b); cin = 0; res = 0;
        h = f[5]; s = f[4]; v = f[3]; n = f[2]; z = f[1]; c = f[0];
        r = 8'h00;
        case (op)
            4'd3, 4'd7: begin
                if (op == 4'd7) cin = int'(f[0]);
                res = ai + bi + cin;
                r = res[7:0];
                c = (res > 255);
                h = ((ai % 16) + (bi % 16) + cin) > 15;
                v = (a[7] == b[7]) && (r[7] != a[7]);
                n = r[7]; s = n ^ v; z = (r == 8'h00);
            end
            4'd1, 4'd2, 4'd5, 4'd6: begin
                if (op == 4'd1 || op == 4'd2) cin = int'(f[0]);
                res = ai - bi - cin;
                r = res[7:0];
                c = (res < 0);
                h = (ai % 16) < ((bi % 16) + cin);
                v = (a[7] != b[7]) && (r[7] != a[7]);
                n = r[7]; s = n ^ v;
                z = (op == 4'd1 || op == 4'd2) ? ((r == 8'h00) && f[1]) : (r == 8'h00);
            end
            4'd8, 4'd9, 4'd10: begin
                r = (op == 4'd8) ? (a & b) : (op == 4'd9) ? (a ^ b) : (a | b);
                v = 1'b0; n = r[7]; s = n; z = (r == 8'h00);
            end
            4'd11: r = b;
            default: ;
        endcase
        return {r, h, s, v, n, z, c};
    endfunction

    // External ALU: one-cycle registered latency.
    always @(posedge i_clk) begin
        {i_alu_result, i_alu_flags} <= avr_alu(o_alu_operation, o_alu_op1, o_alu_op2, o_alu_flags);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
        m_flags = 6'h00;
    endtask

    task automatic load(input logic [4:0] a, input logic [7:0] v);
        i_ld_en = 1'b1; i_ld_addr = a; i_ld_data = v;
        tick();
        i_ld_en = 1'b0;
        m_regs[a] = v;
    endtask

    // Runs one instruction through accept/ISSUE/WB, optionally loading during WB.
    task automatic run_instr(input logic [15:0] w, input logic wb_ld, input logic [4:0] ld_a,
                             input logic [7:0] ld_v, output logic [7:0] seen_op1,
                             output logic seen_skip);
        logic [3:0]  op;
        logic [4:0]  d, r;
        logic        legal, exp_done, exp_ill, exp_skip, wr_rd, wr_sreg;
        logic [13:0] ar;
        op = w[13:10]; d = w[8:4]; r = {w[9], w[3:0]};
        legal = (w[15:14] == 2'b00) && (op != 4'd0);
        check("ready_idle", o_instr_ready, 1);
        i_instr_valid = 1'b1; i_instr = w;
        tick();
        i_instr_valid = 1'b0; i_instr = 16'($urandom);
        check("ready_issue", o_instr_ready, 0);
        check("done_issue", o_done, 0);
        check("alu_op", o_alu_operation, legal ? op : 4'd0);
        if (legal) begin
            check("alu_op1", o_alu_op1, m_regs[d]);
            check("alu_op2", o_alu_op2, m_regs[r]);
            check("alu_flags", o_alu_flags, m_flags);
        end
        seen_op1 = o_alu_op1;
        ar = avr_alu(op, m_regs[d], m_regs[r], m_flags);
        if (legal) begin
            exp_done = 1'b1; exp_ill = 1'b0;
            exp_skip = (op == 4'd4) && (m_regs[d] == m_regs[r]);
            wr_rd    = !(op inside {4'd1, 4'd4, 4'd5});
            wr_sreg  = !(op inside {4'd4, 4'd11});
        end else begin
`ifdef ALU_ISSUE_ILLEGAL_EN
            exp_done = 1'b0; exp_ill = 1'b1;
`else
            exp_done = 1'b1; exp_ill = 1'b0;
`endif
            exp_skip = 1'b0; wr_rd = 1'b0; wr_sreg = 1'b0;
        end
        tick();
        check("done_wb", o_done, exp_done);
        check("skip_wb", o_skip, exp_skip);
        check("illegal_wb", o_illegal, exp_ill);
        check("ready_wb", o_instr_ready, 0);
        check("alu_op_wb", o_alu_operation, 0);
        seen_skip = o_skip;
        if (wb_ld) begin
            i_ld_en = 1'b1; i_ld_addr = ld_a; i_ld_data = ld_v;
        end
        tick();
        i_ld_en = 1'b0;
        if (wb_ld && !(wr_rd && ld_a == d)) m_regs[ld_a] = ld_v;
        if (wr_rd) m_regs[d] = ar[13:6];
        if (wr_sreg) m_flags = ar[5:0];
        check("sreg", o_sreg, {2'b00, m_flags});
        check("done_after", o_done, 0);
    endtask

    task automatic peek(input logic [4:0] a, output logic [7:0] v);
        logic sk;
        run_instr({2'b00, 4'b0100, a[4], a, a[3:0]}, 1'b0, 5'd0, 8'h00, v, sk);
    endtask

    typedef struct {
        logic [4:0]  a_addr;
        logic [7:0]  a_val;
        logic [4:0]  b_addr;
        logic [7:0]  b_val;
        logic [15:0] instr;
        logic [4:0]  rd;
        logic [7:0]  exp_rd;
        logic        exp_skip;
        logic [7:0]  exp_sreg;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [7:0]  v;
        logic        sk;
        logic [15:0] w;
        logic [3:0]  op;
        logic [4:0]  d, r, la;

        vecs[0]  = '{5'd1,  8'h0F, 5'd2,  8'h01, 16'h0C12, 5'd1,  8'h10, 1'b0, 8'h20};
        vecs[1]  = '{5'd3,  8'h00, 5'd4,  8'h01, 16'h1834, 5'd3,  8'hFF, 1'b0, 8'h35};
        vecs[2]  = '{5'd5,  8'h42, 5'd6,  8'h42, 16'h1056, 5'd5,  8'h42, 1'b1, 8'h35};
        vecs[3]  = '{5'd5,  8'h42, 5'd6,  8'h43, 16'h1056, 5'd5,  8'h42, 1'b0, 8'h35};
        vecs[4]  = '{5'd7,  8'h10, 5'd8,  8'h10, 16'h1478, 5'd7,  8'h10, 1'b0, 8'h02};
        vecs[5]  = '{5'd7,  8'h10, 5'd8,  8'h10, 16'h0478, 5'd7,  8'h10, 1'b0, 8'h02};
        vecs[6]  = '{5'd9,  8'h11, 5'd10, 8'h01, 16'h149A, 5'd9,  8'h11, 1'b0, 8'h00};
        vecs[7]  = '{5'd7,  8'h10, 5'd8,  8'h10, 16'h0478, 5'd7,  8'h10, 1'b0, 8'h00};
        vecs[8]  = '{5'd3,  8'h00, 5'd4,  8'h01, 16'h1834, 5'd3,  8'hFF, 1'b0, 8'h35};
        vecs[9]  = '{5'd0,  8'hA5, 5'd31, 8'h00, 16'h2DF0, 5'd31, 8'hA5, 1'b0, 8'h35};
        vecs[10] = '{5'd16, 8'h7F, 5'd17, 8'h00, 16'h1F01, 5'd16, 8'h80, 1'b0, 8'h2C};
        vecs[11] = '{5'd18, 8'hF0, 5'd19, 8'h3C, 16'h2323, 5'd18, 8'h30, 1'b0, 8'h20};
        vecs[12] = '{5'd20, 8'h55, 5'd20, 8'h55, 16'h2744, 5'd20, 8'h00, 1'b0, 8'h22};
        vecs[13] = '{5'd21, 8'h80, 5'd22, 8'h01, 16'h2B56, 5'd21, 8'h81, 1'b0, 8'h34};
        vecs[14] = '{5'd23, 8'h00, 5'd24, 8'h00, 16'h0B78, 5'd23, 8'h00, 1'b0, 8'h00};

        // clock / reset
        i_reset = 1'b1; i_instr_valid = 1'b0; i_instr = 16'h0000;
        i_ld_en = 1'b0; i_ld_addr = 5'd0; i_ld_data = 8'h00;
        model_reset();
        tick(); tick();
        i_reset = 1'b0;
        check("rst_ready", o_instr_ready, 1);
        check("rst_done", o_done, 0);
        check("rst_skip", o_skip, 0);
        check("rst_illegal", o_illegal, 0);
        check("rst_alu", {o_alu_operation, o_alu_op1, o_alu_op2, o_alu_flags}, 0);
        check("rst_sreg", o_sreg, 8'h00);

        // directed table
        for (int i = 0; i < 15; i++) begin
            load(vecs[i].a_addr, vecs[i].a_val);
            load(vecs[i].b_addr, vecs[i].b_val);
            run_instr(vecs[i].instr, 1'b0, 5'd0, 8'h00, v, sk);
            check("tbl_skip", sk, vecs[i].exp_skip);
            check("tbl_sreg", o_sreg, vecs[i].exp_sreg);
            peek(vecs[i].rd, v);
            check("tbl_rd", v, vecs[i].exp_rd);
        end

        // load to Rd during the MOV write-back is dropped
        load(5'd0, 8'h5A);
        run_instr(16'h2DF0, 1'b1, 5'd31, 8'h77, v, sk);
        peek(5'd31, v);
        check("wb_wins", v, 8'h5A);
        // load to another register during write-back still lands
        load(5'd1, 8'h0F); load(5'd2, 8'h01);
        run_instr(16'h0C12, 1'b1, 5'd9, 8'h3C, v, sk);
        peek(5'd9, v);
        check("both_write", v, 8'h3C);
        peek(5'd1, v);
        check("both_write_rd", v, 8'h10);

        // illegal encodings
        run_instr(16'h9508, 1'b0, 5'd0, 8'h00, v, sk);
        run_instr(16'h0012, 1'b0, 5'd0, 8'h00, v, sk);
        peek(5'd1, v);
        check("illegal_no_write", v, 8'h10);

        // reset during ISSUE discards the instruction
        load(5'd1, 8'h55);
        i_instr_valid = 1'b1; i_instr = 16'h0C12;
        tick();
        i_instr_valid = 1'b0; i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        model_reset();
        check("midrst_ready", o_instr_ready, 1);
        check("midrst_done", o_done, 0);
        check("midrst_sreg", o_sreg, 8'h00);
        tick();
        check("midrst_done2", o_done, 0);
        check("midrst_ready2", o_instr_ready, 1);
        peek(5'd1, v);
        check("midrst_reg", v, 8'h00);

        // handshake while reset is high is ignored
        i_reset = 1'b1; i_instr_valid = 1'b1; i_instr = 16'h0C12;
        tick();
        i_reset = 1'b0; i_instr_valid = 1'b0;
        check("rst_hs_ready", o_instr_ready, 1);
        tick();
        check("rst_hs_done", o_done, 0);

        // randomized against the reference model
        for (int n = 0; n < 250; n++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                load(5'($urandom), 8'($urandom));
            end
            op = 4'($urandom_range(1, 11));
            d = 5'($urandom);
            r = ($urandom_range(0, 9) < 3) ? d : 5'($urandom);
            w = {2'b00, op, r[4], d, r[3:0]};
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) w = {6'b000000, 10'($urandom)};
                else w = {2'($urandom_range(1, 3)), 14'($urandom)};
            end
            la = ($urandom_range(0, 1) == 0) ? d : 5'($urandom);
            run_instr(w, ($urandom_range(0, 3) == 0), la, 8'($urandom), v, sk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
